// File: rtl/mvm_stream_loader_if.sv
// ----------------------------------------------------------------------------
// mvm_stream_loader_if
//
// 32-bit word stream with a last marker, used for both the input (matrix then
// vector words) and output (result words) sides of mvm_stream_loader.
//
// Handshake: the producer raises valid with data/last and holds all three
// unchanged until it sees ready high at a rising clock edge; a word moves on
// exactly the edges where valid && ready. ready may depend on state only and
// is never a function of valid.
//
// Signals
//   data   32  word payload
//   valid  1   producer has a word
//   last   1   word is the final one of its group
//   ready  1   consumer accepts the word
//
// Modports
//   master  producer side (drives data/valid/last, samples ready)
//   slave   consumer side (samples data/valid/last, drives ready)
// ----------------------------------------------------------------------------
interface mvm_stream_loader_if;
    logic [31:0] data;
    logic        valid;
    logic        last;
    logic        ready;

    modport master (
        output data,
        output valid,
        output last,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  last,
        output ready
    );
endinterface

// File: rtl/mvm_stream_loader.sv
// ----------------------------------------------------------------------------
// mvm_stream_loader
//
// Streaming wrapper around matrix_vector_multiplier. Collects a row-major
// R x C matrix followed by a C-element vector from the input stream, presents
// them as parallel arrays, pulses mvm_start, captures the R result words when
// mvm_done arrives and streams them out on the output stream. Payload words
// (IEEE-754 single) are passed through untouched.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   s              input stream (slave): matrix words 0..R*C-1, then vector
//                  words; last expected on word R*C+C-1
//   m              output stream (master): R result words, last on word R-1
//   mvm_matrix     [0:R*C-1] matrix to multiplier
//   mvm_vector     [0:C-1] vector to multiplier
//   mvm_start      one-cycle start pulse to multiplier
//   mvm_result     [0:R-1] results from multiplier
//   mvm_done       multiplier done strobe (only honoured while waiting)
//   busy           high whenever a new load cannot be accepted
//   err_early      sticky: last seen before the final word
//   err_nolast     sticky: final word arrived without last
//   err_timeout    sticky: mvm_done not seen within TIMEOUT_CYCLES
//   dbg_state      current FSM state (LOAD=0, START=1, WAIT=2, DRAIN=3)
// ----------------------------------------------------------------------------
module mvm_stream_loader #(
    parameter int MATRIX_ROWS    = 4,
    parameter int MATRIX_COLS    = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,

    mvm_stream_loader_if.slave   s,
    mvm_stream_loader_if.master  m,

    output logic [31:0]          mvm_matrix [0:MATRIX_ROWS*MATRIX_COLS-1],
    output logic [31:0]          mvm_vector [0:MATRIX_COLS-1],
    output logic                 mvm_start,
    input  logic [31:0]          mvm_result [0:MATRIX_ROWS-1],
    input  logic                 mvm_done,

    output logic                 busy,
    output logic                 err_early,
    output logic                 err_nolast,
    output logic                 err_timeout,
    output logic [1:0]           dbg_state
);

    localparam int R        = MATRIX_ROWS;
    localparam int C        = MATRIX_COLS;
    localparam int RC       = R * C;
    localparam int N_WORDS  = RC + C;
    localparam int LAST_IDX = N_WORDS - 1;
    localparam int CW       = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int IW       = (R > 1) ? $clog2(R) : 1;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [CW-1:0]   word_cnt;
    logic [TW-1:0]   wait_cnt;
    logic [IW-1:0]   idx;
    logic [31:0]     result_buf [0:R-1];

    logic            s_fire;
    logic            m_fire;
    logic            final_word;
    logic            wait_expired;
    logic            drain_last;

    // Handshake qualifiers come straight from the state register so that
    // ready never depends on valid.
    assign s_fire       = s.valid && (state_q == ST_LOAD);
    assign m_fire       = m.ready && (state_q == ST_DRAIN);
    assign final_word   = (word_cnt == CW'(LAST_IDX));
    // A done on the last WAIT cycle takes priority over the timeout.
    assign wait_expired = (state_q == ST_WAIT) && !mvm_done &&
                          (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign drain_last   = (idx == IW'(R - 1));
    assign dbg_state    = state_q;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: begin
                // The final word always launches, even without last.
                if (s_fire && final_word) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mvm_done) begin
                    state_d = ST_DRAIN;
                end else if (wait_expired) begin
                    state_d = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (m_fire && drain_last) begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        s.ready   = (state_q == ST_LOAD);
        mvm_start = (state_q == ST_START);
        busy      = (state_q != ST_LOAD);
        m.valid   = (state_q == ST_DRAIN);
        m.last    = (state_q == ST_DRAIN) && drain_last;
        m.data    = 32'd0;
        for (int i = 0; i < R; i++) begin
            if (idx == IW'(i)) begin
                m.data = result_buf[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Input word counter and load-framing errors
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt   <= '0;
            err_early  <= 1'b0;
            err_nolast <= 1'b0;
        end else if (s_fire) begin
            if (final_word) begin
                word_cnt <= '0;
                if (!s.last) begin
                    err_nolast <= 1'b1;
                end
            end else if (s.last) begin
                // Abandon the partial load; stored words are simply
                // overwritten by the next load.
                word_cnt  <= '0;
                err_early <= 1'b1;
            end else begin
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Matrix / vector storage. Writes only happen in LOAD, so the arrays
    // stay stable from START until the operation finishes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RC; i++) begin
                mvm_matrix[i] <= 32'd0;
            end
            for (int j = 0; j < C; j++) begin
                mvm_vector[j] <= 32'd0;
            end
        end else if (s_fire) begin
            for (int i = 0; i < RC; i++) begin
                if (word_cnt == CW'(i)) begin
                    mvm_matrix[i] <= s.data;
                end
            end
            for (int j = 0; j < C; j++) begin
                if (word_cnt == CW'(RC + j)) begin
                    mvm_vector[j] <= s.data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // WAIT cycle counter and timeout flag. The counter is held at zero
    // outside WAIT so it starts from zero on every entry.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (state_q == ST_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (wait_expired) begin
                err_timeout <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result capture (done is ignored outside WAIT) and drain index.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < R; i++) begin
                result_buf[i] <= 32'd0;
            end
        end else if ((state_q == ST_WAIT) && mvm_done) begin
            for (int i = 0; i < R; i++) begin
                result_buf[i] <= mvm_result[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (m_fire) begin
            if (drain_last) begin
                idx <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule
